ntt_coef_packer: RTL and testbench

NTT_COEF_PACKER -- requirements
Module: ntt_coef_packer

---
 rtl/ntt_coef_packer.sv | 183 ++++++++++++++++++
 tb/tb_ntt_coef_packer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_coef_packer.sv
// ntt_coef_packer: gathers 16 coefficients into a 4x4 tile and streams it
// as 4 beats of 4 lanes to a transpose buffer. It alternates the buffer
// direction after every group of 4 beats. After the last tile of a frame it
// inserts 4 empty drain beats so the buffer can flush.
// Optional build macro: COEF_REDUCE_EN (conditional subtraction of Q on store).
module ntt_coef_packer #(
   parameter int unsigned WIDTH = 32,
   parameter logic [22:0] Q     = 23'd8380417,
   parameter int unsigned N     = 256
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               s_valid,
   input  logic [WIDTH-1:0]   s_data,
   input  logic               s_last,
   output logic               s_ready,
   input  logic               clr_err,
   output logic [4*WIDTH-1:0] m_data,
   output logic               m_en,
   output logic               m_valid,
   output logic               m_last,
   output logic               err_range,
   output logic               err_frame
);

   localparam int unsigned TILES = N / 16;
   localparam int unsigned TW    = (TILES > 1) ? $clog2(TILES) : 1;
   localparam int unsigned CW    = $clog2(N);

   typedef enum logic [1:0] {FILL, EMIT, DRAIN} state_t;

   state_t             state_q, state_d;
   logic [3:0]         k_q, k_d;          // coefficient slot within tile
   logic [1:0]         beat_q, beat_d;    // beat index in EMIT, cycle index in DRAIN
   logic [TW-1:0]      tile_q, tile_d;
   logic [CW-1:0]      cnt_q, cnt_d;      // coefficient index within frame
   logic [4*WIDTH-1:0] m_data_q, m_data_d;
   logic               m_valid_q, m_valid_d;
   logic               m_last_q, m_last_d;
   logic               m_en_q, m_en_d;
   logic               err_range_q, err_range_d;
   logic               err_frame_q, err_frame_d;

   logic [WIDTH-1:0]   buf_q [16];
   logic [WIDTH-1:0]   coef_st;
   logic               coef_oor;
   logic               accept;
   logic               last_tile;
   logic               frame_end;
   logic [1:0]         bsel;
   logic [4*WIDTH-1:0] beat_word;

`ifdef COEF_REDUCE_EN
   localparam logic [WIDTH+1:0] QX  = (WIDTH+2)'(Q);
   localparam logic [WIDTH+1:0] Q2X = QX << 1;
   logic [WIDTH+1:0] s_ext;

   // Conditional subtraction of Q; inputs at or above 2Q cannot be fully reduced
   always_comb begin
      s_ext    = {2'b00, s_data};
      coef_oor = (s_ext >= Q2X);
      coef_st  = s_data;
      if (s_ext >= QX) coef_st = WIDTH'(s_ext - QX);
   end
`else
   assign coef_st  = s_data;
   assign coef_oor = 1'b0;
`endif

   assign s_ready   = (state_q == FILL);
   assign accept    = s_valid && s_ready;
   assign last_tile = (tile_q == TW'(TILES - 1));
   assign frame_end = (cnt_q == CW'(N - 1));
   // The beat loaded into the output register is always the one shown next cycle
   assign bsel      = (state_q == EMIT) ? beat_q + 2'd1 : 2'd0;

   // Gather lanes of the selected beat: slot k lives in beat k/4, lane k%4
   always_comb begin
      beat_word = '0;
      for (int l = 0; l < 4; l++) begin
         beat_word[l*WIDTH +: WIDTH] = buf_q[{bsel, 2'(l)}];
      end
   end

   // Tile storage; contents need no reset since a reset restarts filling at slot 0
   always_ff @(posedge clk) begin
      if (accept) buf_q[k_q] <= coef_st;
   end

   // Next-state and registered-output logic
   always_comb begin
      state_d     = state_q;
      k_d         = k_q;
      beat_d      = beat_q;
      tile_d      = tile_q;
      cnt_d       = cnt_q;
      m_data_d    = '0;
      m_valid_d   = 1'b0;
      m_last_d    = 1'b0;
      m_en_d      = m_en_q;
      err_frame_d = err_frame_q && !clr_err;
      err_range_d = err_range_q && !clr_err;
      unique case (state_q)
         FILL: begin
            if (accept) begin
               k_d   = k_q + 4'd1;
               cnt_d = frame_end ? '0 : cnt_q + 1'b1;
               if (s_last != frame_end) err_frame_d = 1'b1;
               if (coef_oor) err_range_d = 1'b1;
               if (k_q == 4'd15) begin
                  state_d   = EMIT;
                  beat_d    = 2'd0;
                  m_data_d  = beat_word;
                  m_valid_d = 1'b1;
               end
            end
         end
         EMIT: begin
            if (beat_q == 2'd3) begin
               m_en_d = !m_en_q;
               beat_d = 2'd0;
               if (last_tile) begin
                  state_d = DRAIN;
               end else begin
                  state_d = FILL;
                  tile_d  = tile_q + 1'b1;
               end
            end else begin
               beat_d    = beat_q + 2'd1;
               m_data_d  = beat_word;
               m_valid_d = 1'b1;
               m_last_d  = last_tile && (beat_q == 2'd2);
            end
         end
         DRAIN: begin
            beat_d = beat_q + 2'd1;
            if (beat_q == 2'd3) begin
               m_en_d  = !m_en_q;
               state_d = FILL;
               tile_d  = '0;
            end
         end
         default: state_d = FILL;
      endcase
   end

   // State and output registers with asynchronous reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= FILL;
         k_q         <= '0;
         beat_q      <= '0;
         tile_q      <= '0;
         cnt_q       <= '0;
         m_data_q    <= '0;
         m_valid_q   <= 1'b0;
         m_last_q    <= 1'b0;
         m_en_q      <= 1'b0;
         err_range_q <= 1'b0;
         err_frame_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         beat_q      <= beat_d;
         tile_q      <= tile_d;
         cnt_q       <= cnt_d;
         m_data_q    <= m_data_d;
         m_valid_q   <= m_valid_d;
         m_last_q    <= m_last_d;
         m_en_q      <= m_en_d;
         err_range_q <= err_range_d;
         err_frame_q <= err_frame_d;
      end
   end

   assign m_data    = m_data_q;
   assign m_valid   = m_valid_q;
   assign m_last    = m_last_q;
   assign m_en      = m_en_q;
   assign err_range = err_range_q;
   assign err_frame = err_frame_q;

endmodule

// File: tb/tb_ntt_coef_packer.sv
// Testbench for ntt_coef_packer: directed vector table, hand-written corner
// sequences and randomized traffic checked against a tile-level reference model.
// Honours COEF_REDUCE_EN the same way as the design.
module tb_ntt_coef_packer;

   localparam int    W  = 32;
   localparam int    N  = 256;
   localparam longint QV = 8380417;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             s_valid, s_last, clr_err;
   logic [W-1:0]     s_data;
   logic             s_ready;
   logic [4*W-1:0]   m_data;
   logic             m_en, m_valid, m_last, err_range, err_frame;

   ntt_coef_packer dut (
      .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data),
      .s_last(s_last), .s_ready(s_ready), .clr_err(clr_err),
      .m_data(m_data), .m_en(m_en), .m_valid(m_valid), .m_last(m_last),
      .err_range(err_range), .err_frame(err_frame)
   );

   always #5 clk = ~clk;

   // expected output/readiness for one cycle
   typedef struct {
      logic           rdy;
      logic           vld;
      logic [4*W-1:0] dat;
      logic           last;
      logic           en;
   } exp_t;

   typedef struct {
      logic           v;
      logic [W-1:0]   d;
      logic           rdy;
      logic           vld;
      logic [4*W-1:0] dat;
      logic           en;
   } vec_t;

   int tests = 0;
   int fails = 0;
   int nvld, nlast;

   // reference model state
   exp_t          expq[$];
   exp_t          cur;
   logic [W-1:0]  tbuf[16];
   int            mk, mcnt, mtile;
   logic          men, merrf, merrr;

   function automatic logic [W-1:0] model_store(input logic [W-1:0] c);
`ifdef COEF_REDUCE_EN
      if (longint'(c) >= QV) return W'(longint'(c) - QV);
`endif
      return c;
   endfunction

   function automatic logic model_oor(input logic [W-1:0] c);
`ifdef COEF_REDUCE_EN
      return longint'(c) >= 2 * QV;
`else
      return 1'b0;
`endif
   endfunction

   task automatic chk(input string nm, input logic [4*W-1:0] act, input logic [4*W-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic model_clear();
      expq.delete();
      mk = 0; mcnt = 0; mtile = 0;
      men = 1'b0; merrf = 1'b0; merrr = 1'b0;
      cur = '{rdy: 1'b1, vld: 1'b0, dat: '0, last: 1'b0, en: 1'b0};
   endtask

   // One clock: drive inputs, advance model at the edge, compare just after it
   task automatic tick(input logic v, input logic [W-1:0] d, input logic l,
                       input logic clr, output logic acc);
      logic newf, newr, fin;
      exp_t e;
      s_valid = v; s_data = d; s_last = l; clr_err = clr;
      acc = v && cur.rdy;
      @(posedge clk);
      newf = 1'b0; newr = 1'b0;
      if (acc) begin
         tbuf[mk] = model_store(d);
         newr = model_oor(d);
         newf = (l != (mcnt == N - 1));
         mk++;
         mcnt = (mcnt == N - 1) ? 0 : mcnt + 1;
         if (mk == 16) begin
            mk  = 0;
            fin = (mtile == N / 16 - 1);
            for (int b = 0; b < 4; b++) begin
               e.rdy = 1'b0; e.vld = 1'b1; e.en = men;
               e.last = fin && (b == 3);
               e.dat = {tbuf[4*b+3], tbuf[4*b+2], tbuf[4*b+1], tbuf[4*b]};
               expq.push_back(e);
            end
            men = !men;
            if (fin) begin
               for (int b = 0; b < 4; b++)
                  expq.push_back('{rdy: 1'b0, vld: 1'b0, dat: '0, last: 1'b0, en: men});
               men = !men;
               mtile = 0;
            end else begin
               mtile++;
            end
         end
      end
      merrf = (merrf && !clr) || newf;
      merrr = (merrr && !clr) || newr;
      if (expq.size() > 0) cur = expq.pop_front();
      else cur = '{rdy: 1'b1, vld: 1'b0, dat: '0, last: 1'b0, en: men};
      #1;
      chk("s_ready", s_ready, cur.rdy);
      chk("m_valid", m_valid, cur.vld);
      chk("m_data", m_data, cur.dat);
      chk("m_last", m_last, cur.last);
      chk("m_en", m_en, cur.en);
      chk("err_frame", err_frame, merrf);
      chk("err_range", err_range, merrr);
      if (m_valid === 1'b1) nvld++;
      if (m_last === 1'b1) nlast++;
   endtask

   // Offer one coefficient (after optional random idle) until accepted, bounded
   task automatic push(input logic [W-1:0] d, input logic l, input bit rnd_idle);
      logic a;
      if (rnd_idle && ($urandom_range(0, 1) == 1)) tick(1'b0, '0, 1'b0, 1'b0, a);
      a = 1'b0;
      for (int t = 0; t < 20 && !a; t++) tick(1'b1, d, l, 1'b0, a);
      if (!a) begin
         tests++; fails++;
         $display("FAIL push_timeout: got not-accepted expected accepted");
      end
   endtask

   task automatic idle(input int n);
      logic a;
      for (int i = 0; i < n; i++) tick(1'b0, '0, 1'b0, 1'b0, a);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_data", m_data, 0);
      chk("rst_m_last", m_last, 0);
      chk("rst_m_en", m_en, 0);
      chk("rst_err_range", err_range, 0);
      chk("rst_err_frame", err_frame, 0);
      chk("rst_s_ready", s_ready, 1);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      model_clear();
   endtask

   vec_t tbl[20];

   initial begin
      logic a;
      rst_n = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; clr_err = 1'b0;
      model_clear();
      // directed table: 0..15 with s_valid held, then the 4 emit beats
      for (int i = 0; i < 20; i++) begin
         tbl[i].v   = (i < 19);
         tbl[i].d   = (i < 16) ? W'(i) : W'(99);
         tbl[i].rdy = (i < 15) || (i == 19);
         tbl[i].vld = (i >= 15) && (i <= 18);
         tbl[i].dat = '0;
         if (tbl[i].vld) begin
            for (int l = 0; l < 4; l++)
               tbl[i].dat[l*W +: W] = W'(4 * (i - 15) + l);
         end
         tbl[i].en  = (i == 19);
      end
      #3;
      do_reset();

      // scenario: 16 coefficients, beat timing and lanes
      nvld = 0; nlast = 0;
      for (int i = 0; i < 20; i++) begin
         tick(tbl[i].v, tbl[i].d, 1'b0, 1'b0, a);
         chk($sformatf("tbl%0d_rdy", i), s_ready, tbl[i].rdy);
         chk($sformatf("tbl%0d_vld", i), m_valid, tbl[i].vld);
         chk($sformatf("tbl%0d_dat", i), m_data, tbl[i].dat);
         chk($sformatf("tbl%0d_en", i), m_en, tbl[i].en);
      end

      // complete the frame with stalls; one m_last, 64 valid beats
      for (int i = 16; i < N; i++)
         push($urandom_range(0, int'(QV) - 1), (mcnt == N - 1), 1'b1);
      idle(12);
      chk("frame1_beats", nvld, 64);
      chk("frame1_lasts", nlast, 1);

      // misplaced s_last at coefficient 100, frame still completes normally
      nvld = 0; nlast = 0;
      for (int i = 0; i < N; i++) begin
         push($urandom_range(0, int'(QV) - 1), (mcnt == 100) || (mcnt == N - 1), 1'b0);
         if (i == 100) chk("err_frame_set", err_frame, 1);
      end
      idle(12);
      chk("frame2_beats", nvld, 64);
      chk("frame2_lasts", nlast, 1);
      tick(1'b0, '0, 1'b0, 1'b1, a);
      chk("err_frame_clr", err_frame, 0);

      // modulus boundary values
      push(W'(8380417), 1'b0, 1'b0);
      chk("range_q", err_range, 0);
      push(W'(8380418), 1'b0, 1'b0);
      chk("range_q1", err_range, 0);
      push(W'(16760834), 1'b0, 1'b0);
`ifdef COEF_REDUCE_EN
      chk("range_2q", err_range, 1);
`else
      chk("range_2q", err_range, 0);
`endif
      for (int i = 3; i < 16; i++) push(W'(i), 1'b0, 1'b0);
`ifdef COEF_REDUCE_EN
      chk("reduce_beat0", m_data, {32'd3, 32'd8380417, 32'd1, 32'd0});
`else
      chk("reduce_beat0", m_data, {32'd3, 32'd16760834, 32'd8380418, 32'd8380417});
`endif
      tick(1'b0, '0, 1'b0, 1'b1, a);
      chk("err_range_clr", err_range, 0);
      idle(4);

      // reset during emit beat 2
      for (int i = 0; i < 16; i++) push($urandom_range(0, 1000), 1'b0, 1'b0);
      idle(2);
      chk("pre_reset_beat2_vld", m_valid, 1);
      do_reset();
      for (int i = 0; i < 16; i++) push(W'(100 + i), 1'b0, 1'b0);
      chk("post_reset_vld", m_valid, 1);
      chk("post_reset_en", m_en, 0);
      chk("post_reset_beat0", m_data, {32'd103, 32'd102, 32'd101, 32'd100});
      idle(4);

      // random traffic: random valid, full-range data, rare framing errors/clears
      for (int i = 0; i < 2 * N; i++) begin
         logic lv;
         logic cl;
         lv = (mcnt == N - 1) ^ ($urandom_range(0, 99) == 0);
         cl = ($urandom_range(0, 19) == 0);
         tick($urandom_range(0, 1) == 1, $urandom(), lv, cl, a);
      end
      idle(12);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
